// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_MIS = 2'b01,
        ERR_TMO = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lo[0];
            SZ_WORD: misaligned = (lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering: load byte/half extraction with extension, store replication and mask.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  store_mask
);

    logic [15:0] sel;

    always_comb begin
        sel        = 16'(rdata >> {addr_lo, 3'b000});
        load_data  = rdata;
        store_data = wdata;
        store_mask = 4'b1111;
        case (size)
            SZ_BYTE: begin
                load_data  = uns ? {24'b0, sel[7:0]} : {{24{sel[7]}}, sel[7:0]};
                store_data = {4{wdata[7:0]}};
                store_mask = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                load_data  = uns ? {16'b0, sel} : {{16{sel[15]}}, sel};
                store_data = {2{wdata[15:0]}};
                store_mask = 4'b0011 << addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access to a PMEM responder with alignment check and timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_e        state, state_n;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          wen_q, uns_q;
    size_e         size_q;
    err_e          err_q;
    logic [CW-1:0] cnt;
    logic [31:0]   load_data, store_data;
    logic [3:0]    store_mask;
    logic          req_bad;

    assign req_bad = misaligned(size_e'(req_size), req_addr[1:0]);

    lsu_lane u_lane (
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .load_data  (load_data),
        .store_data (store_data),
        .store_mask (store_mask)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = req_bad ? RESP : REQ;
            REQ:     if (mem_ready || cnt == LAST) state_n = RESP;
            RESP:    if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            err_q   <= ERR_OK;
            cnt     <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    wen_q   <= req_wen;
                    uns_q   <= req_unsigned;
                    size_q  <= size_e'(req_size);
                    rdata_q <= '0;
                    cnt     <= '0;
                    err_q   <= req_bad ? ERR_MIS : ERR_OK;
                end
                // mem_ready wins over the timeout on the final counted cycle
                REQ: if (mem_ready) begin
                    rdata_q <= wen_q ? '0 : load_data;
                    err_q   <= ERR_OK;
                end else if (cnt == LAST) begin
                    err_q <= ERR_TMO;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid ? err_q : ERR_OK;
    assign mem_valid  = (state == REQ);
    assign mem_raddr  = {addr_q[31:2], 2'b00};
    assign mem_waddr  = {addr_q[31:2], 2'b00};
    assign mem_wen    = mem_valid & wen_q;
    assign mem_wdata  = mem_wen ? store_data : '0;
    assign mem_wmask  = mem_wen ? store_mask : '0;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles waited for mem_ready before a timeout error.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  upstream access request.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, LSB-aligned.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  2  00 ok, 01 misaligned or illegal size, 10 timeout.
REQ-015 mem_valid  output  1  memory access request to the PMEM responder.
REQ-016 mem_ready  input  1  responder done; tie high for a combinational responder.
REQ-017 mem_raddr, mem_waddr  output  32  word-aligned address {addr[31:2],2'b00}; both carry the same value.
REQ-018 mem_rdata  input  32  read word, valid while mem_valid && mem_ready.
REQ-019 mem_wen  output  1  store request.
REQ-020 mem_wdata  output  32  lane-replicated store data.
REQ-021 mem_wmask  output  4  byte-lane enable.

Function
REQ-022 The FSM SHALL have states IDLE, REQ and RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 On acceptance, the unit SHALL register addr, wen, wdata, size and unsigned, then enter REQ the next cycle, or RESP if the request is misaligned or illegal.
REQ-024 Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=3; such requests SHALL make no memory access and SHALL set resp_err=01.
REQ-025 In REQ, mem_valid SHALL be 1 and all mem_* outputs SHALL stay stable until the cycle mem_ready=1.
REQ-026 On the cycle REQ sees mem_ready=1, the unit SHALL latch the extracted rdata (0 for stores) and enter RESP; minimum latency is accept to resp_valid in 2 cycles.
REQ-027 A REQ-cycle counter SHALL count from 0; reaching TIMEOUT without mem_ready SHALL set resp_err=10 and enter RESP with mem_valid dropped.
REQ-028 mem_ready arriving on the same cycle the counter hits TIMEOUT SHALL count as success.
REQ-029 In RESP, resp_valid SHALL be 1 with the data and error held; on resp_ready the FSM SHALL return to IDLE, with the next request accepted no earlier than the following cycle.
REQ-030 Store lanes: byte SHALL drive wdata={4{b}} and wmask=4'b0001<<addr[1:0]; half SHALL drive {2{h}} and 4'b0011<<addr[1:0]; word SHALL drive wdata with mask 4'b1111.
REQ-031 Load extraction SHALL select the byte or half from lane addr[1:0] and extend per req_unsigned; word loads SHALL pass through unchanged.
REQ-032 mem_wen, mem_wmask and mem_wdata SHALL be 0 whenever mem_valid=0 or the access is a load.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE, the counter 0, and every output 0 except req_ready, which SHALL be 1.
REQ-034 Reset asserted mid-access SHALL abort immediately with no response; mem_valid SHALL drop asynchronously.

Structure
REQ-035 Package lsu_pkg SHALL hold the size encodings, the resp_err codes and the state enum.
REQ-036 Sub-module lsu_lane SHALL hold the combinational load extraction/extension and store lane/mask generation; lsu SHALL hold the FSM, the registers and the counter.

Verification
REQ-037 Store byte: addr=0x80000003, wdata=0xAB, mem_ready=1 -> mem_waddr=0x80000000, wdata=0xABABABAB, wmask=1000, resp_err=00.
REQ-038 Signed load half: addr=0x80000002, mem_rdata=0x8001FFFF -> resp_rdata=0xFFFF8001; with req_unsigned=1 -> 0x00008001.
REQ-039 Misaligned word: addr=0x80000001 -> mem_valid never 1, resp_valid after 1 cycle, resp_err=01, resp_rdata=0.
REQ-040 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_valid high 4 cycles then low, resp_err=10.
REQ-041 Backpressure and reset: resp_ready low 3 cycles -> response held stable and req_ready=0; then rst_n pulsed low during REQ -> all outputs 0 except req_ready=1, and no resp_valid follows.
